// File: rtl/nuc_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : nuc_frame_ctrl
//  Purpose  : Frame-level sequencer in front of the NUC stream wrapper.
//             Gates the gain / offset / raw AXI4-Stream handshakes so that
//             NUC processing starts and stops on frame boundaries, latches
//             bypass only between frames, and recovers from coefficient/raw
//             line misalignment by draining every stream to its own end of
//             frame. Only tvalid/tready/tlast pass through; tdata is wired
//             around this block.
//  Ports    : axis_aclk, axis_areset (sync, active-high)
//             enable, bypass_req, err_clr           - control inputs
//             bypass, busy, frame_cnt               - status outputs
//             err_align, err_timeout                - sticky error flags
//             s_axis_{gain,ofst,raw}_{tvalid,tlast,tready}  - upstream side
//             m_axis_{gain,ofst,raw}_{tvalid,tlast,tready}  - NUC side
//  Options  : NUC_FRAME_TIMEOUT_EN - builds a stall watchdog that returns the
//             block to IDLE after TIMEOUT_CYCLES cycles without any beat.
//  Revision : 1.0 - initial release
// ============================================================================
module nuc_frame_ctrl #(
    parameter int LINES_PER_FRAME = 480,
    parameter int LCNT_WIDTH      = 10,
    parameter int FCNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES  = 1048576
) (
    input  logic                  axis_aclk,
    input  logic                  axis_areset,
    input  logic                  enable,
    input  logic                  bypass_req,
    output logic                  bypass,
    input  logic                  s_axis_gain_tvalid,
    input  logic                  s_axis_gain_tlast,
    output logic                  s_axis_gain_tready,
    input  logic                  s_axis_ofst_tvalid,
    input  logic                  s_axis_ofst_tlast,
    output logic                  s_axis_ofst_tready,
    input  logic                  s_axis_raw_tvalid,
    input  logic                  s_axis_raw_tlast,
    output logic                  s_axis_raw_tready,
    output logic                  m_axis_gain_tvalid,
    output logic                  m_axis_gain_tlast,
    input  logic                  m_axis_gain_tready,
    output logic                  m_axis_ofst_tvalid,
    output logic                  m_axis_ofst_tlast,
    input  logic                  m_axis_ofst_tready,
    output logic                  m_axis_raw_tvalid,
    output logic                  m_axis_raw_tlast,
    input  logic                  m_axis_raw_tready,
    output logic                  busy,
    output logic [FCNT_WIDTH-1:0] frame_cnt,
    output logic                  err_align,
    output logic                  err_timeout,
    input  logic                  err_clr
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_flush = 2'd2;

    localparam logic [LCNT_WIDTH-1:0] c_last_line = LCNT_WIDTH'(LINES_PER_FRAME - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_bypass;
    logic [FCNT_WIDTH-1:0] r_frame_cnt;
    logic                  r_err_align;
    logic [LCNT_WIDTH-1:0] r_lcnt_g, r_lcnt_o, r_lcnt_r;
    logic                  r_done_g, r_done_o, r_done_r;

    logic w_run, w_flush;
    logic w_beat_g, w_beat_o, w_beat_r;
    logic w_eof_g, w_eof_o, w_eof_r;
    logic w_misalign, w_frame_ok, w_load, w_clr_cnt, w_timeout;

    function automatic logic [LCNT_WIDTH-1:0] f_lcnt_nxt(input logic [LCNT_WIDTH-1:0] cnt);
        return (cnt == c_last_line) ? '0 : cnt + LCNT_WIDTH'(1);
    endfunction

    assign w_run  = (r_state == c_st_run);
    assign w_flush = (r_state == c_st_flush);
    assign busy   = (r_state != c_st_idle);

    // Pass-through is purely combinational in RUN; FLUSH swallows beats
    // until each stream has reached its own end of frame.
    always_comb begin
        m_axis_gain_tvalid = w_run & s_axis_gain_tvalid;
        m_axis_ofst_tvalid = w_run & s_axis_ofst_tvalid;
        m_axis_raw_tvalid  = w_run & s_axis_raw_tvalid;
        s_axis_gain_tready = w_run ? m_axis_gain_tready : (w_flush & ~r_done_g);
        s_axis_ofst_tready = w_run ? m_axis_ofst_tready : (w_flush & ~r_done_o);
        s_axis_raw_tready  = w_run ? m_axis_raw_tready  : (w_flush & ~r_done_r);
    end

    assign m_axis_gain_tlast = s_axis_gain_tlast;
    assign m_axis_ofst_tlast = s_axis_ofst_tlast;
    assign m_axis_raw_tlast  = s_axis_raw_tlast;

    assign w_beat_g = s_axis_gain_tvalid & s_axis_gain_tready;
    assign w_beat_o = s_axis_ofst_tvalid & s_axis_ofst_tready;
    assign w_beat_r = s_axis_raw_tvalid  & s_axis_raw_tready;

    assign w_eof_g = w_beat_g & s_axis_gain_tlast & (r_lcnt_g == c_last_line);
    assign w_eof_o = w_beat_o & s_axis_ofst_tlast & (r_lcnt_o == c_last_line);
    assign w_eof_r = w_beat_r & s_axis_raw_tlast  & (r_lcnt_r == c_last_line);

    // Every raw beat must be accompanied by coefficient beats on the same
    // line position; a tlast disagreement means the streams have slipped.
    assign w_misalign = w_run & w_beat_r &
                        ~(w_beat_g & w_beat_o &
                          (s_axis_gain_tlast == s_axis_raw_tlast) &
                          (s_axis_ofst_tlast == s_axis_raw_tlast));

    assign w_frame_ok = w_run & w_eof_r & ~w_misalign;

    // Next-state logic; w_load latches bypass at a frame start, w_clr_cnt
    // zeroes line counters and flush-done flags.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_clr_cnt   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (enable) begin
                    w_state_nxt = c_st_run;
                    w_load      = 1'b1;
                    w_clr_cnt   = 1'b1;
                end
            end
            c_st_run: begin
                if (w_misalign) begin
                    w_state_nxt = c_st_flush;
                end else if (w_eof_r) begin
                    if (enable) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = c_st_idle;
                    end
                end
            end
            c_st_flush: begin
                if (r_done_g & r_done_o & r_done_r) begin
                    w_clr_cnt = 1'b1;
                    if (enable) begin
                        w_state_nxt = c_st_run;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = c_st_idle;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_clr_cnt   = 1'b1;
            end
        endcase
        if (w_timeout) begin
            w_state_nxt = c_st_idle;
            w_load      = 1'b0;
            w_clr_cnt   = 1'b1;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            r_bypass    <= 1'b0;
            r_frame_cnt <= '0;
            r_err_align <= 1'b0;
            r_lcnt_g    <= '0;
            r_lcnt_o    <= '0;
            r_lcnt_r    <= '0;
            r_done_g    <= 1'b0;
            r_done_o    <= 1'b0;
            r_done_r    <= 1'b0;
        end else begin
            if (w_load) begin
                r_bypass <= bypass_req;
            end
            if (w_frame_ok) begin
                r_frame_cnt <= r_frame_cnt + FCNT_WIDTH'(1);
            end
            // Set wins over clear when both land in the same cycle.
            if (w_misalign) begin
                r_err_align <= 1'b1;
            end else if (err_clr) begin
                r_err_align <= 1'b0;
            end
            if (w_clr_cnt) begin
                r_lcnt_g <= '0;
                r_lcnt_o <= '0;
                r_lcnt_r <= '0;
                r_done_g <= 1'b0;
                r_done_o <= 1'b0;
                r_done_r <= 1'b0;
            end else begin
                if (w_beat_g & s_axis_gain_tlast) r_lcnt_g <= f_lcnt_nxt(r_lcnt_g);
                if (w_beat_o & s_axis_ofst_tlast) r_lcnt_o <= f_lcnt_nxt(r_lcnt_o);
                if (w_beat_r & s_axis_raw_tlast)  r_lcnt_r <= f_lcnt_nxt(r_lcnt_r);
                if (w_flush & w_eof_g) r_done_g <= 1'b1;
                if (w_flush & w_eof_o) r_done_o <= 1'b1;
                if (w_flush & w_eof_r) r_done_r <= 1'b1;
            end
        end
    end

    assign bypass    = r_bypass;
    assign frame_cnt = r_frame_cnt;
    assign err_align = r_err_align;

`ifdef NUC_FRAME_TIMEOUT_EN
    localparam int c_wd_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_wd_w-1:0] r_wdog;
    logic              r_err_timeout;
    logic              w_any_beat;

    assign w_any_beat = w_beat_g | w_beat_o | w_beat_r;
    // Fires on the cycle that would take the idle count to TIMEOUT_CYCLES.
    assign w_timeout  = busy & ~w_any_beat & (r_wdog == c_wd_w'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            r_wdog        <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            if (~busy | w_any_beat | (w_state_nxt != r_state)) begin
                r_wdog <= '0;
            end else begin
                r_wdog <= r_wdog + c_wd_w'(1);
            end
            if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end else if (err_clr) begin
                r_err_timeout <= 1'b0;
            end
        end
    end

    assign err_timeout = r_err_timeout;
`else
    assign w_timeout   = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule
`default_nettype wire
